// File: rtl/fifo111_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo111_ctrl_if
// Description : Push/pop handshake and status bundle of the fifo111_ctrl
//               FIFO controller.
//               slave  - controller side (receives requests, drives status)
//               master - user side (drives requests, receives status)
//               Push : wr_req, wr_dat
//               Pop  : rd_req, rd_dat, rd_vld
//               Ctrl : flush
//               Stat : full, empty, afull, count, ovf, udf
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo111_ctrl_if #(
    parameter int ADDRBIT = 9,
    parameter int WIDTH   = 32
);
    logic               wr_req;
    logic [WIDTH-1:0]   wr_dat;
    logic               rd_req;
    logic               flush;
    logic [WIDTH-1:0]   rd_dat;
    logic               rd_vld;
    logic               full;
    logic               empty;
    logic               afull;
    logic [ADDRBIT:0]   count;
    logic               ovf;
    logic               udf;

    modport slave (
        input  wr_req, wr_dat, rd_req, flush,
        output rd_dat, rd_vld, full, empty, afull, count, ovf, udf
    );

    modport master (
        output wr_req, wr_dat, rd_req, flush,
        input  rd_dat, rd_vld, full, empty, afull, count, ovf, udf
    );
endinterface
`default_nettype wire

// File: rtl/fifo111_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo111_ctrl
// Description : Pointer/flag controller for a FIFO built on an external
//               synchronous dual-port array with a registered read output.
//               Arbitrary DEPTH (no power-of-two requirement).
//               Ports:
//                 clk, rst       - clock, asynchronous active-high reset
//                 bus (slave)    - push/pop handshake, flush and status
//                 mem_we/wa/di   - array write port (same-cycle as push)
//                 mem_ra/mem_do  - array read port (1-cycle latency)
//                 mem_rst_       - active-low array reset (~rst)
//               Build option:
//                 FIFO111_STICKY_ERR_EN - ovf/udf sticky until rst/flush;
//                 otherwise single-cycle registered pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo111_ctrl #(
    parameter int ADDRBIT   = 9,
    parameter int DEPTH     = 512,
    parameter int WIDTH     = 32,
    parameter int AFULL_LVL = DEPTH - 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fifo111_ctrl_if.slave           bus,
    output logic                    mem_we,
    output logic [ADDRBIT-1:0]      mem_wa,
    output logic [WIDTH-1:0]        mem_di,
    output logic [ADDRBIT-1:0]      mem_ra,
    input  wire logic [WIDTH-1:0]   mem_do,
    output logic                    mem_rst_
);

    localparam logic [ADDRBIT:0]   c_DEPTH_CNT = (ADDRBIT+1)'(DEPTH);
    localparam logic [ADDRBIT:0]   c_AFULL_CNT = (ADDRBIT+1)'(AFULL_LVL);
    localparam logic [ADDRBIT-1:0] c_LAST_PTR  = ADDRBIT'(DEPTH - 1);

    logic [ADDRBIT-1:0] r_wr_ptr;
    logic [ADDRBIT-1:0] r_rd_ptr;
    logic [ADDRBIT:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_afull;
    logic               r_rd_vld;
    logic               r_ovf;
    logic               r_udf;

    logic               w_push;
    logic               w_pop;
    logic               w_ovf_evt;
    logic               w_udf_evt;
    logic [ADDRBIT-1:0] w_wr_ptr_nxt;
    logic [ADDRBIT-1:0] w_rd_ptr_nxt;
    logic [ADDRBIT:0]   w_count_nxt;

    // Acceptance uses the registered flags, so a push on full (or a pop on
    // empty) is refused even when the opposite side is active this cycle.
    assign w_push    = bus.wr_req & ~r_full  & ~bus.flush;
    assign w_pop     = bus.rd_req & ~r_empty & ~bus.flush;
    assign w_ovf_evt = bus.wr_req & r_full;
    assign w_udf_evt = bus.rd_req & r_empty;

    // Explicit wrap so DEPTH need not be a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + ADDRBIT'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + ADDRBIT'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDRBIT+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (ADDRBIT+1)'(1);
        end
    end

    // Flags are derived from the next count so they carry no lag vs. count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_DEPTH_CNT);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= c_AFULL_CNT);
            r_rd_vld <= w_pop;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
                if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
`ifdef FIFO111_STICKY_ERR_EN
            if (bus.flush) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_ovf_evt) r_ovf <= 1'b1;
                if (w_udf_evt) r_udf <= 1'b1;
            end
`else
            r_ovf <= w_ovf_evt;
            r_udf <= w_udf_evt;
`endif
        end
    end

    // Write enable is gated by rst: full is low during reset, so an
    // incoming wr_req would otherwise reach the array.
    assign mem_we   = w_push & ~rst;
    assign mem_wa   = r_wr_ptr;
    assign mem_di   = bus.wr_dat;
    assign mem_ra   = r_rd_ptr;
    assign mem_rst_ = ~rst;

    assign bus.rd_dat = mem_do;
    assign bus.rd_vld = r_rd_vld;
    assign bus.full   = r_full;
    assign bus.empty  = r_empty;
    assign bus.afull  = r_afull;
    assign bus.count  = r_count;
    assign bus.ovf    = r_ovf;
    assign bus.udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo111_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo111_ctrl
// Description : Directed bench for fifo111_ctrl (DEPTH=4, AFULL_LVL=3,
//               WIDTH=8) with a registered-output array model.
//               Expectations follow FIFO111_STICKY_ERR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo111_ctrl;

    localparam int ADDRBIT = 2;
    localparam int DEPTH   = 4;
    localparam int WIDTH   = 8;
    localparam int AFULL   = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_we;
    logic [ADDRBIT-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_di;
    logic [ADDRBIT-1:0] mem_ra;
    logic [WIDTH-1:0]   mem_do;
    logic               mem_rst_;

    logic [WIDTH-1:0]   mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    fifo111_ctrl_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) bus ();

    fifo111_ctrl #(
        .ADDRBIT   (ADDRBIT),
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_we   (mem_we),
        .mem_wa   (mem_wa),
        .mem_di   (mem_di),
        .mem_ra   (mem_ra),
        .mem_do   (mem_do),
        .mem_rst_ (mem_rst_)
    );

    always #5 clk = ~clk;

    // Array model: synchronous write, registered read, cleared output on reset.
    always @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_di;
        mem_do <= mem_rst_ ? mem[mem_ra] : '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_sticky;
    logic [7:0] exp_d;

    initial begin
`ifdef FIFO111_STICKY_ERR_EN
        exp_sticky = 1'b1;
`else
        exp_sticky = 1'b0;
`endif
        bus.wr_req = 1'b0;
        bus.wr_dat = '0;
        bus.rd_req = 1'b0;
        bus.flush  = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_count",  32'(bus.count), 32'd0);
        chk("rst_empty",  32'(bus.empty), 32'd1);
        chk("rst_full",   32'(bus.full),  32'd0);
        chk("rst_afull",  32'(bus.afull), 32'd0);
        chk("rst_rdvld",  32'(bus.rd_vld), 32'd0);
        chk("rst_ovf",    32'(bus.ovf),   32'd0);
        chk("rst_udf",    32'(bus.udf),   32'd0);
        chk("rst_memrst", 32'(mem_rst_),  32'd0);
        rst = 1'b0;
        step();
        chk("rel_memrst", 32'(mem_rst_),  32'd1);

        // ---------------- fill 0x11..0x44 ----------------
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1'b1;
            bus.wr_dat = 8'(8'h11 * (i + 1));
            #1;
            chk("push_we", 32'(mem_we), 32'd1);
            chk("push_wa", 32'(mem_wa), 32'(i));
            chk("push_di", 32'(mem_di), 32'(8'h11 * (i + 1)));
            step();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_afull", 32'(bus.afull), (i + 1 >= 3) ? 32'd1 : 32'd0);
            chk("fill_full",  32'(bus.full),  (i + 1 == 4) ? 32'd1 : 32'd0);
        end
        bus.wr_req = 1'b0;

        // ---------------- drain, 1-cycle read latency ----------------
        for (int i = 0; i < 4; i++) begin
            bus.rd_req = 1'b1;
            #1;
            chk("pop_ra", 32'(mem_ra), 32'(i));
            step();
            bus.rd_req = 1'b0;
            chk("drain_vld", 32'(bus.rd_vld), 32'd1);
            chk("drain_dat", 32'(bus.rd_dat), 32'(8'h11 * (i + 1)));
            chk("drain_cnt", 32'(bus.count), 32'(3 - i));
        end
        step();
        chk("idle_vld",    32'(bus.rd_vld), 32'd0);
        chk("drain_empty", 32'(bus.empty),  32'd1);

        // ---------------- push+pop on full ----------------
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1'b1;
            bus.wr_dat = 8'(8'hA1 + i);
            step();
        end
        chk("full2", 32'(bus.full), 32'd1);
        bus.wr_dat = 8'hEE;
        bus.rd_req = 1'b1;
        #1;
        chk("full_we_blocked", 32'(mem_we), 32'd0);
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        chk("full_ovf",  32'(bus.ovf),    32'd1);
        chk("full_cnt",  32'(bus.count),  32'd3);
        chk("full_vld",  32'(bus.rd_vld), 32'd1);
        chk("full_dat",  32'(bus.rd_dat), 32'hA1);
        step();
        chk("ovf_after", 32'(bus.ovf), 32'(exp_sticky));
        for (int i = 1; i < 4; i++) begin
            bus.rd_req = 1'b1;
            step();
            bus.rd_req = 1'b0;
            chk("full_drain_dat", 32'(bus.rd_dat), 32'(8'hA1 + i));
        end
        step();
        chk("full_drain_empty", 32'(bus.empty), 32'd1);

        // ---------------- push+pop on empty ----------------
        bus.wr_req = 1'b1;
        bus.wr_dat = 8'h55;
        bus.rd_req = 1'b1;
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        chk("emp_udf", 32'(bus.udf),    32'd1);
        chk("emp_cnt", 32'(bus.count),  32'd1);
        chk("emp_vld", 32'(bus.rd_vld), 32'd0);
        step();
        chk("udf_after", 32'(bus.udf), 32'(exp_sticky));
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk("emp_pop_vld", 32'(bus.rd_vld), 32'd1);
        chk("emp_pop_dat", 32'(bus.rd_dat), 32'h55);
        step();

        // ---------------- wrap: 10 push/pop pairs at count 2 ----------------
        bus.wr_req = 1'b1;
        bus.wr_dat = 8'h60;
        step();
        bus.wr_dat = 8'h61;
        step();
        for (int k = 0; k < 10; k++) begin
            bus.wr_dat = 8'(8'h62 + k);
            bus.rd_req = 1'b1;
            step();
            exp_d = 8'(8'h60 + k);
            chk("wrap_dat", 32'(bus.rd_dat), 32'(exp_d));
            chk("wrap_vld", 32'(bus.rd_vld), 32'd1);
            chk("wrap_cnt", 32'(bus.count),  32'd2);
        end
        bus.rd_req = 1'b0;

        // ---------------- flush at count 3 with both requests ----------------
        bus.wr_dat = 8'h6C;
        step();
        chk("pre_flush_cnt", 32'(bus.count), 32'd3);
        chk("pre_flush_ovf", 32'(bus.ovf), 32'(exp_sticky));
        bus.wr_dat = 8'hF0;
        bus.rd_req = 1'b1;
        bus.flush  = 1'b1;
        #1;
        chk("flush_we", 32'(mem_we), 32'd0);
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.flush  = 1'b0;
        chk("flush_cnt",   32'(bus.count),  32'd0);
        chk("flush_empty", 32'(bus.empty),  32'd1);
        chk("flush_afull", 32'(bus.afull),  32'd0);
        chk("flush_vld",   32'(bus.rd_vld), 32'd0);
        chk("flush_ovf",   32'(bus.ovf),    32'd0);
        chk("flush_udf",   32'(bus.udf),    32'd0);
        #1;
        chk("flush_ra", 32'(mem_ra), 32'd0);
        chk("flush_wa", 32'(mem_wa), 32'd0);

        // ---------------- async reset right after a pop ----------------
        bus.wr_req = 1'b1;
        bus.wr_dat = 8'h77;
        step();
        bus.wr_dat = 8'h88;
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        step();
        chk("prerst_vld", 32'(bus.rd_vld), 32'd1);
        chk("prerst_dat", 32'(bus.rd_dat), 32'h77);
        bus.wr_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_vld",    32'(bus.rd_vld), 32'd0);
        chk("arst_cnt",    32'(bus.count),  32'd0);
        chk("arst_empty",  32'(bus.empty),  32'd1);
        chk("arst_memrst", 32'(mem_rst_),   32'd0);
        chk("arst_we",     32'(mem_we),     32'd0);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("postrst_vld", 32'(bus.rd_vld), 32'd0);
        chk("postrst_cnt", 32'(bus.count),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fifo111_ctrl.md
FIFO111_CTRL -- requirements
Module: fifo111_ctrl

Interface
REQ-001 SHALL provide parameter ADDRBIT, default 9, array address width.
REQ-002 SHALL provide parameter DEPTH, default 512, number of entries, 2 <= DEPTH <= 2^ADDRBIT, not required to be a power of two.
REQ-003 SHALL provide parameter WIDTH, default 32, data width.
REQ-004 SHALL provide parameter AFULL_LVL, default DEPTH-4, almost-full threshold, 1 <= AFULL_LVL <= DEPTH.
REQ-005 SHALL have one clock and an asynchronous, active-high reset. Ports: clk  in  1  sole clock, all logic on posedge; rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the following push-side ports: wr_req  in  1  push request; wr_dat  in  WIDTH  push data.
REQ-007 SHALL have the following pop-side and control ports: rd_req  in  1  pop request; flush  in  1  synchronous empty command.
REQ-008 SHALL have the following pop-data ports: rd_dat  out  WIDTH  pop data, equal to mem_do; rd_vld  out  1  rd_dat valid.
REQ-009 SHALL have the following status ports: full  out  1; empty  out  1; afull  out  1; count  out  ADDRBIT+1  occupancy.
REQ-010 SHALL have the following error ports: ovf  out  1  push rejected; udf  out  1  pop rejected.
REQ-011 SHALL have the following array write-port ports: mem_we  out  1; mem_wa  out  ADDRBIT; mem_di  out  WIDTH.
REQ-012 SHALL have the following array read-port ports: mem_ra  out  ADDRBIT; mem_do  in  WIDTH  registered array output; mem_rst_  out  1  active-low array reset, equal to ~rst.

Function
REQ-013 SHALL accept a push iff wr_req=1, full=0 and flush=0; on acceptance mem_we=1, mem_wa=wr_ptr and mem_di=wr_dat combinationally in the same cycle.
REQ-014 SHALL accept a pop iff rd_req=1, empty=0 and flush=0; mem_ra SHALL always equal rd_ptr.
REQ-015 SHALL assert rd_vld exactly one cycle after each accepted pop, with rd_dat carrying the entry at the popped address (1-cycle read latency).
REQ-016 SHALL advance wr_ptr and rd_ptr by 1 on acceptance, wrapping from DEPTH-1 to 0.
REQ-017 SHALL update count as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-018 SHALL generate full=(count==DEPTH), empty=(count==0) and afull=(count>=AFULL_LVL), all as registered state with no extra cycle of lag versus count.
REQ-019 SHALL reject a push when full, including when a pop is requested in the same cycle (no write-through on full).
REQ-020 SHALL reject a pop when empty, including when a push is requested in the same cycle; read-during-write to the same address therefore never occurs.
REQ-021 SHALL, on flush=1, set wr_ptr, rd_ptr and count to 0 at the next edge, force rd_vld=0 that edge, and leave array contents untouched; flush has priority over push and pop.
REQ-022 SHALL assert ovf when wr_req=1 and full=1, and udf when rd_req=1 and empty=1; behaviour is selected per REQ-026.

Reset
REQ-023 SHALL, while rst=1, asynchronously force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, afull=0, rd_vld=0, ovf=0, udf=0 and mem_we=0.
REQ-024 SHALL, on reset asserted mid-operation, discard all in-flight pops, so that no rd_vld follows reset release.
REQ-025 SHALL drive mem_rst_=0 while rst=1 so that the array clears to its reset value.

Configuration
REQ-026 SHALL use macro FIFO111_STICKY_ERR_EN as follows: when defined, ovf/udf are sticky, set on the event and cleared only by rst or flush; when undefined, ovf/udf are registered single-cycle pulses, one cycle after each rejected request.

Verification (DEPTH=4, AFULL_LVL=3, WIDTH=8)
REQ-027 SHALL cover: after reset, push 0x11,0x22,0x33,0x44 -> count 1..4, afull at count 3, full at 4; pop x4 -> rd_dat 0x11,0x22,0x33,0x44, each with rd_vld 1 cycle after the pop, then empty=1.
REQ-028 SHALL cover: full, then wr_req+rd_req same cycle -> push rejected, ovf set, count 4->3, rd_dat=oldest entry next cycle.
REQ-029 SHALL cover: empty, then wr_req(0x55)+rd_req same cycle -> pop rejected, udf set, count 0->1; next pop returns 0x55.
REQ-030 SHALL cover: 10 push/pop pairs at count 2 -> pointers wrap past 3->0, data order preserved, count stays 2.
REQ-031 SHALL cover: flush with wr_req+rd_req at count 3 -> count 0, empty=1, no rd_vld next cycle, sticky flags cleared (macro on), or a pulse observed exactly once (macro off).
REQ-032 SHALL cover: rst asserted the cycle after a pop -> rd_vld=0, all outputs at reset values immediately (asynchronous), mem_rst_=0.
